add16u_err_monitor: RTL

//  Downstream characterisation stage for the 16-bit approximate adders. Takes each operand

---
 rtl/add16u_errmon_pkg.sv | 39 +++
 rtl/add16u_errmon_dist.sv | 87 ++++++++
 rtl/add16u_err_monitor.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/add16u_errmon_pkg.sv
// Package for the approximate-adder error monitor.
//  - errmon_state_t : batch controller states
//  - PIPE_DEPTH     : cycles the controller waits in DRAIN after the last transfer
//  - DEF_*          : default widths for the monitor parameters
//  - sat_add()      : saturating add on a wide scratch width; callers pass the
//                     real accumulator width in w and truncate the result.
package add16u_errmon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } errmon_state_t;

  localparam int PIPE_DEPTH = 2;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 20;
  localparam int DEF_ACC_W = 40;

  // Scratch width for sat_add; must exceed every accumulator width used
  // (including the 2*ACC_W square-sum) so acc + inc cannot wrap.
  localparam int SAT_W = 128;

  // Returns min(acc + inc, 2**w - 1). Works even if inc alone exceeds the limit.
  function automatic logic [SAT_W-1:0] sat_add(
    input logic [SAT_W-1:0] acc,
    input logic [SAT_W-1:0] inc,
    input int unsigned      w
  );
    logic [SAT_W-1:0] lim;
    logic [SAT_W-1:0] sum;
    lim = (SAT_W'(1) << w) - SAT_W'(1);
    sum = acc + inc;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/add16u_errmon_dist.sv
// Error-distance stage of the monitor.
//  Operands are registered on transfer as (exact = a+b, o); the next register
//  holds err = |o - exact| (and err*err when ADD16U_ERRMON_MSE_EN is defined),
//  each with a valid bit. The result for a transfer accepted at edge t is
//  presented on out_valid/err after edge t+1.
// Ports:
//  clk, rst_n     clock, asynchronous active-low reset
//  in_valid       a sample is transferred this cycle
//  a, b           operands (WIDTH)
//  o              approximate adder result (WIDTH+1)
//  out_valid      err (and sq) hold a new sample
//  err            unsigned |o - (a+b)| (WIDTH+1)
//  sq             err*err (2*WIDTH+2), only with ADD16U_ERRMON_MSE_EN
module add16u_errmon_dist
  import add16u_errmon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   o,
  output logic             out_valid,
  output logic [WIDTH:0]   err
`ifdef ADD16U_ERRMON_MSE_EN
  ,
  output logic [2*WIDTH+1:0] sq
`endif
);

  logic             cap_valid_reg;
  logic [WIDTH:0]   exact_reg;
  logic [WIDTH:0]   o_reg;
  logic             err_valid_reg;
  logic [WIDTH:0]   err_reg;
  logic [WIDTH:0]   err_next;

  // Capture: exact sum is formed as the operands are registered, so the
  // subtract/abs path below starts from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid_reg <= 1'b0;
      exact_reg     <= '0;
      o_reg         <= '0;
    end else begin
      cap_valid_reg <= in_valid;
      if (in_valid) begin
        exact_reg <= {1'b0, a} + {1'b0, b};
        o_reg     <= o;
      end
    end
  end

  assign err_next = (o_reg >= exact_reg) ? (o_reg - exact_reg) : (exact_reg - o_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_reg <= 1'b0;
      err_reg       <= '0;
    end else begin
      err_valid_reg <= cap_valid_reg;
      if (cap_valid_reg) begin
        err_reg <= err_next;
      end
    end
  end

  assign out_valid = err_valid_reg;
  assign err       = err_reg;

`ifdef ADD16U_ERRMON_MSE_EN
  logic [2*WIDTH+1:0] sq_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_reg <= '0;
    end else if (cap_valid_reg) begin
      sq_reg <= (2*WIDTH+2)'(err_next) * (2*WIDTH+2)'(err_next);
    end
  end

  assign sq = sq_reg;
`endif

endmodule

// File: rtl/add16u_err_monitor.sv
// Error-statistics monitor for 16-bit approximate adders.
//  Accepts a programmed batch of (a, b, o) samples and accumulates the
//  saturating sum of |err|, the worst-case |err| and the count of erroneous
//  samples. The host derives MAE/EP from the results after done_o.
//  Optional feature macro: ADD16U_ERRMON_MSE_EN adds sq_sum_o, the saturating
//  sum of err*err (same latency).
// Ports:
//  clk, rst_n     clock, asynchronous active-low reset
//  start_i        begin a batch (honoured in IDLE or DONE only)
//  n_samples_i    batch length, captured on an accepted start
//  in_valid_i     sample valid;  in_ready_o  sample accept
//  a_i, b_i, o_i  operands and approximate result
//  busy_o         high in RUN and DRAIN
//  done_o         one-cycle pulse on entry to DONE
//  abs_sum_o      saturating sum of |err|
//  wce_o          worst-case |err|
//  err_cnt_o      samples with err != 0
//  smp_cnt_o      samples accumulated
//  sq_sum_o       saturating sum of err*err (ADD16U_ERRMON_MSE_EN only)
module add16u_err_monitor
  import add16u_errmon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_samples_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH:0]   o_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [ACC_W-1:0] abs_sum_o,
  output logic [WIDTH:0]   wce_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] smp_cnt_o
`ifdef ADD16U_ERRMON_MSE_EN
  ,
  output logic [2*ACC_W-1:0] sq_sum_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [1:0]       DRAIN_INIT = 2'(PIPE_DEPTH - 1);

  errmon_state_t    state_reg;
  logic [CNT_W-1:0] n_reg;
  logic [CNT_W-1:0] acc_cnt_reg;
  logic [1:0]       drain_cnt_reg;
  logic             in_ready_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [ACC_W-1:0] abs_sum_reg;
  logic [ACC_W-1:0] abs_sum_next;
  logic [WIDTH:0]   wce_reg;
  logic [CNT_W-1:0] err_cnt_reg;
  logic [CNT_W-1:0] smp_cnt_reg;

  logic             xfer;
  logic             start_ok;
  logic             last_xfer;
  logic             s1_valid;
  logic [WIDTH:0]   s1_err;

  // in_ready_reg is only ever set in RUN, so xfer never fires outside RUN.
  assign xfer      = in_valid_i & in_ready_reg;
  assign start_ok  = start_i & ((state_reg == IDLE) | (state_reg == DONE));
  assign last_xfer = xfer & ((acc_cnt_reg + CNT_ONE) == n_reg);

`ifdef ADD16U_ERRMON_MSE_EN
  logic [2*WIDTH+1:0] s1_sq;
  logic [2*ACC_W-1:0] sq_sum_reg;
`endif

  add16u_errmon_dist #(
    .WIDTH (WIDTH)
  ) u_dist (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (xfer),
    .a         (a_i),
    .b         (b_i),
    .o         (o_i),
    .out_valid (s1_valid),
    .err       (s1_err)
`ifdef ADD16U_ERRMON_MSE_EN
    ,
    .sq        (s1_sq)
`endif
  );

  // Batch controller. in_ready drops on the edge of the n-th transfer, so a
  // sample offered afterwards is never accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      n_reg         <= '0;
      acc_cnt_reg   <= '0;
      drain_cnt_reg <= '0;
      in_ready_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start_i) begin
            n_reg       <= n_samples_i;
            acc_cnt_reg <= '0;
            if (n_samples_i == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg    <= RUN;
              in_ready_reg <= 1'b1;
              busy_reg     <= 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            acc_cnt_reg <= acc_cnt_reg + CNT_ONE;
          end
          if (last_xfer) begin
            in_ready_reg  <= 1'b0;
            state_reg     <= DRAIN;
            drain_cnt_reg <= DRAIN_INIT;
          end
        end
        DRAIN: begin
          // The last sample reaches the accumulators on the same edge that
          // enters DONE, so results are final while done_o is high.
          if (drain_cnt_reg == '0) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - 2'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign abs_sum_next = ACC_W'(sat_add(SAT_W'(abs_sum_reg), SAT_W'(s1_err), ACC_W));

  // Statistics accumulators; bubbles leave them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_sum_reg <= '0;
      wce_reg     <= '0;
      err_cnt_reg <= '0;
      smp_cnt_reg <= '0;
    end else if (start_ok) begin
      abs_sum_reg <= '0;
      wce_reg     <= '0;
      err_cnt_reg <= '0;
      smp_cnt_reg <= '0;
    end else if (s1_valid) begin
      abs_sum_reg <= abs_sum_next;
      if (s1_err > wce_reg) begin
        wce_reg <= s1_err;
      end
      if (s1_err != '0) begin
        err_cnt_reg <= err_cnt_reg + CNT_ONE;
      end
      smp_cnt_reg <= smp_cnt_reg + CNT_ONE;
    end
  end

`ifdef ADD16U_ERRMON_MSE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_sum_reg <= '0;
    end else if (start_ok) begin
      sq_sum_reg <= '0;
    end else if (s1_valid) begin
      sq_sum_reg <= (2*ACC_W)'(sat_add(SAT_W'(sq_sum_reg), SAT_W'(s1_sq), 2*ACC_W));
    end
  end

  assign sq_sum_o = sq_sum_reg;
`endif

  assign in_ready_o = in_ready_reg;
  assign busy_o     = busy_reg;
  assign done_o     = done_reg;
  assign abs_sum_o  = abs_sum_reg;
  assign wce_o      = wce_reg;
  assign err_cnt_o  = err_cnt_reg;
  assign smp_cnt_o  = smp_cnt_reg;

endmodule
